seq_divider: RTL and testbench

Multi-cycle, parametrised restoring divider. It computes an unsigned integer quotient and remainder one bit per clock, then optionally continues into base-FRAC_BASE fractional digit groups (e.g. three decimal digits per group when FRAC_BASE=1000). It replaces single-cycle combinational dividers on timing-critical paths of the video pipeline, such as scaling and coordinate math. It sits between a requester and a consumer with valid/ready handshakes on both sides.

---
 rtl/seq_divider.sv | 176 +++++++++++++++++
 tb/tb_seq_divider.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock for the integer
// part, then optional base-FRAC_BASE fractional digit groups.
module seq_divider #(
  parameter int WIDTH       = 10,
  parameter int FRAC_GROUPS = 0,
  parameter int FRAC_BASE   = 1000,
  parameter int FRAC_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic [((FRAC_GROUPS > 0) ? FRAC_GROUPS*FRAC_W : 1)-1:0] frac,
  output logic             dz
);

  localparam int FRW = (FRAC_GROUPS > 0) ? FRAC_GROUPS*FRAC_W : 1;
  localparam int PW  = WIDTH + FRAC_W;
  localparam int CN  = (WIDTH > FRAC_W) ? WIDTH : FRAC_W;
  localparam int CW  = $clog2(CN);
  localparam int GW  = (FRAC_GROUPS > 1) ? $clog2(FRAC_GROUPS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INT  = 2'd1;
  localparam logic [1:0] S_FRAC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             fin_q, fin_d;
  logic             dzw_q, dzw_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [FRAC_W-1:0] fdv_q, fdv_d;
  logic [FRW-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] rint_q, rint_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [FRW-1:0]   frac_q, frac_d;
  logic             dz_q, dz_d;

  logic             bit_in;
  logic             ge;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_n;
  logic [PW-1:0]    prod;

  // One restoring step shared by the integer and fractional phases.
  always_comb begin
    bit_in = (st_q == S_FRAC) ? fdv_q[FRAC_W-1] : sh_q[WIDTH-1];
    trial  = {rem_q, bit_in};
    ge     = (trial >= {1'b0, d_q});
    rem_n  = ge ? (trial[WIDTH-1:0] - d_q) : trial[WIDTH-1:0];
    prod   = PW'(rem_n) * PW'(FRAC_BASE);
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    gcnt_d = gcnt_q;
    fin_d  = fin_q;
    dzw_d  = dzw_q;
    d_d    = d_q;
    rem_d  = rem_q;
    sh_d   = sh_q;
    fdv_d  = fdv_q;
    acc_d  = acc_q;
    rint_d = rint_q;
    q_d    = q_q;
    r_d    = r_q;
    frac_d = frac_q;
    dz_d   = dz_q;
    unique case (st_q)
      S_IDLE: begin
        if (in_valid) begin
          d_d    = d;
          sh_d   = n;
          rem_d  = '0;
          acc_d  = '0;
          rint_d = n;
          cnt_d  = CW'(WIDTH-1);
          dzw_d  = (d == '0);
          fin_d  = (d == '0);
          st_d   = S_INT;
        end
      end
      S_INT, S_FRAC: begin
        // fin_q marks the single wrap-up cycle that registers the result.
        if (fin_q) begin
          q_d    = dzw_q ? '1 : sh_q;
          r_d    = rint_q;
          frac_d = acc_q;
          dz_d   = dzw_q;
          st_d   = S_DONE;
        end else begin
          rem_d = rem_n;
          cnt_d = cnt_q - CW'(1);
          if (st_q == S_INT) begin
            sh_d = {sh_q[WIDTH-2:0], ge};
          end else begin
            fdv_d = fdv_q << 1;
            acc_d = (acc_q << 1) | FRW'(ge);
          end
          if (cnt_q == '0) begin
            if (st_q == S_INT) rint_d = rem_n;
            if ((st_q == S_INT) ? (FRAC_GROUPS == 0) : (gcnt_q == '0)) begin
              fin_d = 1'b1;
            end else begin
              st_d   = S_FRAC;
              cnt_d  = CW'(FRAC_W-1);
              rem_d  = prod[PW-1:FRAC_W];
              fdv_d  = prod[FRAC_W-1:0];
              gcnt_d = (st_q == S_INT) ? GW'(FRAC_GROUPS-1)
                                       : gcnt_q - GW'(1);
            end
          end
        end
      end
      S_DONE: begin
        if (out_ready) st_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      gcnt_q <= '0;
      fin_q  <= 1'b0;
      dzw_q  <= 1'b0;
      d_q    <= '0;
      rem_q  <= '0;
      sh_q   <= '0;
      fdv_q  <= '0;
      acc_q  <= '0;
      rint_q <= '0;
      q_q    <= '0;
      r_q    <= '0;
      frac_q <= '0;
      dz_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      gcnt_q <= gcnt_d;
      fin_q  <= fin_d;
      dzw_q  <= dzw_d;
      d_q    <= d_d;
      rem_q  <= rem_d;
      sh_q   <= sh_d;
      fdv_q  <= fdv_d;
      acc_q  <= acc_d;
      rint_q <= rint_d;
      q_q    <= q_d;
      r_q    <= r_d;
      frac_q <= frac_d;
      dz_q   <= dz_d;
    end
  end

  assign in_ready  = (st_q == S_IDLE);
  assign out_valid = (st_q == S_DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign frac      = frac_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider with two
// three-digit decimal fraction groups.
module tb_seq_divider;

  localparam int W   = 10;
  localparam int G   = 2;
  localparam int B   = 1000;
  localparam int F   = 10;
  localparam int FRW = G*F;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   n = '0;
  logic [W-1:0]   d = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic [FRW-1:0] frac;
  logic           dz;

  int n_chk = 0;
  int n_err = 0;

  seq_divider #(
    .WIDTH(W), .FRAC_GROUPS(G), .FRAC_BASE(B), .FRAC_W(F)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .frac(frac), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where out_valid is seen.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input int gap, output int lat);
    int w;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    n = a;
    d = b;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("result_timeout", 0, 1);
  endtask

  task automatic take(input int gap);
    repeat (gap) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] mkfrac(input int g0, input int g1);
    return (g0 << F) | g1;
  endfunction

  task automatic dir(input string p, input int a, input int b,
                     input int eq, input int er, input int g0,
                     input int g1, input int edz, input int elat);
    int lat;
    send(W'(a), W'(b), 0, lat);
    check({p, ".lat"}, lat, elat);
    check({p, ".q"}, q, eq);
    check({p, ".r"}, r, er);
    check({p, ".frac"}, frac, mkfrac(g0, g1));
    check({p, ".dz"}, dz, edz);
    take(0);
    check({p, ".ov_after"}, out_valid, 0);
    check({p, ".rdy_after"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int a, b, eq, er, g0, r1, g1;
    repeat (2) @(negedge clk);
    check("rst.q", q, 0);
    check("rst.r", r, 0);
    check("rst.frac", frac, 0);
    check("rst.dz", dz, 0);
    check("rst.ov", out_valid, 0);
    check("rst.rdy", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    dir("v1000_7", 1000, 7, 142, 6, 857, 142, 0, 31);
    dir("v5_10", 5, 10, 0, 5, 500, 0, 0, 31);
    dir("v1023_1", 1023, 1, 1023, 0, 0, 0, 0, 31);
    dir("dz77", 77, 0, 1023, 77, 0, 0, 1, 1);
    dir("v10_3", 10, 3, 3, 1, 333, 333, 0, 31);

    // Backpressure with a toggling, ignored in_valid
    send(10'd100, 10'd9, 0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      n = 10'd3;
      d = 10'd1;
      check("bp.ov", out_valid, 1);
      check("bp.rdy", in_ready, 0);
      check("bp.q", q, 11);
      check("bp.r", r, 1);
      check("bp.frac", frac, mkfrac(111, 111));
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp.ov_hold", out_valid, 1);
    take(0);
    check("bp.ov_after", out_valid, 0);
    check("bp.rdy_after", in_ready, 1);

    // Reset during the integer phase
    in_valid = 1'b1;
    n = 10'd500;
    d = 10'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst.q", q, 0);
    check("mrst.r", r, 0);
    check("mrst.frac", frac, 0);
    check("mrst.dz", dz, 0);
    check("mrst.ov", out_valid, 0);
    check("mrst.rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dir("v600_25", 600, 25, 24, 0, 0, 0, 0, 31);

    // Random requests against an arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 1023);
      b = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 1023);
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 15);
      if (b == 0) begin
        eq = 1023; er = a; g0 = 0; g1 = 0;
      end else begin
        eq = a / b;
        er = a % b;
        g0 = (er * B) / b;
        r1 = (er * B) % b;
        g1 = (r1 * B) / b;
      end
      send(W'(a), W'(b), $urandom_range(0, 3), lat);
      check("rnd.lat", lat, (b == 0) ? 1 : 31);
      check("rnd.q", q, eq);
      check("rnd.r", r, er);
      check("rnd.frac", frac, mkfrac(g0, g1));
      check("rnd.dz", dz, (b == 0) ? 1 : 0);
      take($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
